wb_commit_unit: RTL and testbench
=================================

// Module: wb_commit_unit
// PURPOSE
//  Write-side master for the 32x32 register file: collects results from ALU and
//  load/store unit (LSU) over valid/ready, arbitrates one write per cycle, and
//  drives the regfile write port (RegWrite/rd_addr/write_data) from registers.
//  Keeps a busy scoreboard of destination registers so issue logic can stall on RAW.
// PARAMETERS
//  XLEN   32  data width of results and write_data
//  NREG   32  number of architectural registers (busy_mask width)
//  AW     5   register address width, log2(NREG)
// PORTS
//  clk          in   1     clock; all state updates on rising edge
//  rst          in   1     synchronous reset, active-high
//  issue_valid  in   1     instruction with a destination issued this cycle
//  issue_rd     in   AW    destination of issuing instruction
//  busy_mask    out  NREG  bit i = register i has a pending write; bit 0 always 0
//  alu_valid    in   1     ALU result available
//  alu_ready    out  1     ALU result accepted this cycle
//  alu_rd       in   AW    ALU destination register
//  alu_data     in   XLEN  ALU result
//  lsu_valid    in   1     load result available
//  lsu_ready    out  1     load result accepted this cycle
//  lsu_rd       in   AW    load destination register
//  lsu_data     in   XLEN  load result
//  RegWrite     out  1     regfile write enable (registered)
//  rd_addr      out  AW    regfile write address (registered)
//  write_data   out  XLEN  regfile write data (registered)
// BEHAVIOUR
//  Reset: RegWrite=0, rd_addr=0, write_data=0, busy_mask=0, last_grant=ALU;
//   asserted mid-operation drops any accepted-but-uncommitted write; busy cleared.
//  Handshake: transfer when valid&&ready in same cycle. ready is combinational from
//   valid and arbiter state only (never from the other side's ready); never high
//   during rst. Sources hold rd/data stable while valid&&!ready.
//  Arbitration: one grant per cycle. Only one valid -> that source granted.
//   Both valid -> round-robin: grant the source not granted last; last_grant updates
//   only on a transfer. First tie after reset goes to LSU.
//  Latency: accepted in cycle N -> RegWrite=1, rd_addr, write_data presented in
//   cycle N+1; regfile captures at end of N+1. No transfer in N -> RegWrite=0 in N+1,
//   rd_addr/write_data hold previous values.
//  x0: transfer with rd=0 is accepted (ready high) but RegWrite stays 0 in N+1.
//  Scoreboard (per bit, rd!=0): set at edge ending cycle where issue_valid && issue_rd=i;
//   clear at edge ending cycle where RegWrite && rd_addr=i. Set and clear same bit same
//   cycle -> set wins (newer producer outstanding). issue_rd=0 never sets bit 0.
//  Throughput: one commit per cycle sustained; no internal buffering beyond output reg.
//  No checking of writes to non-busy registers; commit proceeds and clear is a no-op.
// TESTING
//  1) rst high 2 cycles, then idle -> RegWrite=0, busy_mask=0, both readys 0 while
//     valids 0; rst with alu_valid=1 -> alu_ready=0.
//  2) issue rd=5, then ALU rd=5 data=0xDEADBEEF valid in N -> alu_ready=1 in N;
//     N+1 RegWrite=1 rd_addr=5 write_data=0xDEADBEEF; busy_mask[5] 1 through N+1, 0 in N+2.
//  3) ALU rd=3 and LSU rd=4 both valid, held 3 cycles after reset -> grants LSU,ALU,LSU;
//     commits rd 4,3,4 on consecutive cycles.
//  4) LSU rd=0 data=0x1234 valid -> lsu_ready=1, next cycle RegWrite=0; busy_mask[0]=0.
//  5) commit of rd=7 (RegWrite=1, rd_addr=7) while issue_rd=7 same cycle ->
//     busy_mask[7]=1 after edge; cleared only by the following rd=7 commit.
//  6) rst asserted in cycle after ALU transfer -> RegWrite=0 next cycle, write lost,
//     busy_mask=0; compare regfile content against model.

Source files
------------

// File: rtl/wb_commit_if.sv
// Bundle of the commit unit's handshake and regfile write-port signals.
// master: the commit unit itself (accepts results, drives the regfile write port).
// slave : the surrounding pipeline (issue logic, ALU, LSU, regfile).
interface wb_commit_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
);
  logic              issue_valid;
  logic [AW-1:0]     issue_rd;
  logic [NREG-1:0]   busy_mask;

  logic              alu_valid;
  logic              alu_ready;
  logic [AW-1:0]     alu_rd;
  logic [XLEN-1:0]   alu_data;

  logic              lsu_valid;
  logic              lsu_ready;
  logic [AW-1:0]     lsu_rd;
  logic [XLEN-1:0]   lsu_data;

  logic              RegWrite;
  logic [AW-1:0]     rd_addr;
  logic [XLEN-1:0]   write_data;

  modport master (
    input  issue_valid, issue_rd,
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output busy_mask, alu_ready, lsu_ready,
    output RegWrite, rd_addr, write_data
  );

  modport slave (
    output issue_valid, issue_rd,
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  busy_mask, alu_ready, lsu_ready,
    input  RegWrite, rd_addr, write_data
  );
endinterface

// File: rtl/wb_commit_unit.sv
// Write-back commit unit: accepts ALU/LSU results over valid/ready, grants at
// most one per cycle (round-robin on ties), presents the winning write on a
// registered regfile write port one cycle later, and keeps a busy scoreboard
// of registers with an outstanding producer.
module wb_commit_unit #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic       clk,
  input  logic       rst,
  wb_commit_if.master bus
);

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

  grant_e            last_grant_q, last_grant_d;
  logic              reg_write_q, reg_write_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   write_data_q, write_data_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic              grant_alu_s;
  logic              grant_lsu_s;
  logic              transfer_s;
  logic [AW-1:0]     sel_rd_s;
  logic [XLEN-1:0]   sel_data_s;

  // Arbiter: single requester wins outright; a tie goes to whichever source
  // did not win the last transfer. Nothing is granted while in reset.
  always_comb begin
    grant_alu_s = 1'b0;
    grant_lsu_s = 1'b0;
    if (!rst) begin
      case ({bus.alu_valid, bus.lsu_valid})
        2'b10:   grant_alu_s = 1'b1;
        2'b01:   grant_lsu_s = 1'b1;
        2'b11: begin
          if (last_grant_q == GRANT_ALU) begin
            grant_lsu_s = 1'b1;
          end else begin
            grant_alu_s = 1'b1;
          end
        end
        default: begin
          grant_alu_s = 1'b0;
          grant_lsu_s = 1'b0;
        end
      endcase
    end else begin
      grant_alu_s = 1'b0;
      grant_lsu_s = 1'b0;
    end
  end

  // Result mux and next values for the registered write port and arbiter history.
  always_comb begin
    transfer_s   = grant_alu_s | grant_lsu_s;
    sel_rd_s     = grant_lsu_s ? bus.lsu_rd   : bus.alu_rd;
    sel_data_s   = grant_lsu_s ? bus.lsu_data : bus.alu_data;
    // x0 results are consumed but never written.
    reg_write_d  = transfer_s && (sel_rd_s != {AW{1'b0}});
    if (transfer_s) begin
      rd_addr_d    = sel_rd_s;
      write_data_d = sel_data_s;
    end else begin
      rd_addr_d    = rd_addr_q;
      write_data_d = write_data_q;
    end
    if (grant_lsu_s) begin
      last_grant_d = GRANT_LSU;
    end else if (grant_alu_s) begin
      last_grant_d = GRANT_ALU;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Scoreboard next state: a commit clears its bit, a same-cycle issue to the
  // same register re-sets it (the newer producer is still outstanding).
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (bus.issue_valid && (bus.issue_rd == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if (reg_write_q && (rd_addr_q == AW'(i))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous reset; reset discards any accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GRANT_ALU;
      reg_write_q  <= 1'b0;
      rd_addr_q    <= {AW{1'b0}};
      write_data_q <= {XLEN{1'b0}};
      busy_q       <= {NREG{1'b0}};
    end else begin
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      rd_addr_q    <= rd_addr_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.alu_ready  = grant_alu_s;
  assign bus.lsu_ready  = grant_lsu_s;
  assign bus.RegWrite   = reg_write_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.write_data = write_data_q;
  assign bus.busy_mask  = busy_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_wb_commit_unit;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_commit_if #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) bus ();

  wb_commit_unit #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Register file attached to the DUT write port (ignores writes during reset).
  logic [XLEN-1:0] dut_rf [NREG] = '{default: '0};
  always @(posedge clk) begin
    if (bus.RegWrite === 1'b1 && !rst) dut_rf[bus.rd_addr] <= bus.write_data;
  end

  // Reference model state.
  logic [XLEN-1:0] m_rf [NREG] = '{default: '0};
  bit              m_last_lsu;
  bit              m_rw;
  logic [AW-1:0]   m_addr;
  logic [XLEN-1:0] m_data;
  logic [NREG-1:0] m_busy;
  bit              exp_alu_rdy;
  bit              exp_lsu_rdy;

  task automatic predict_grants();
    exp_alu_rdy = 1'b0;
    exp_lsu_rdy = 1'b0;
    if (!rst) begin
      if (bus.alu_valid && bus.lsu_valid) begin
        if (m_last_lsu) exp_alu_rdy = 1'b1;
        else            exp_lsu_rdy = 1'b1;
      end else begin
        exp_alu_rdy = bus.alu_valid;
        exp_lsu_rdy = bus.lsu_valid;
      end
    end
  endtask

  // Advance one clock; the model consumes the current inputs as a transaction.
  task automatic clock_cycle();
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
    predict_grants();
    if (m_rw && !rst) m_rf[m_addr] = m_data;
    if (rst) begin
      m_rw = 1'b0; m_addr = '0; m_data = '0; m_busy = '0; m_last_lsu = 1'b0;
    end else begin
      if (m_rw) m_busy[m_addr] = 1'b0;
      if (bus.issue_valid && bus.issue_rd != 5'd0) m_busy[bus.issue_rd] = 1'b1;
      if (exp_alu_rdy || exp_lsu_rdy) begin
        rd   = exp_lsu_rdy ? bus.lsu_rd   : bus.alu_rd;
        data = exp_lsu_rdy ? bus.lsu_data : bus.alu_data;
        m_rw = (rd != 5'd0);
        m_addr = rd;
        m_data = data;
        m_last_lsu = exp_lsu_rdy;
      end else begin
        m_rw = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.issue_valid = 1'b0; bus.issue_rd = 5'd0;
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = 32'd0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (bus.alu_ready !== 1'b0 || bus.lsu_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_ready_idle: alu_ready=%b lsu_ready=%b required 0/0", bus.alu_ready, bus.lsu_ready);
      end
      clock_cycle();
    end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h11;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_alu_ready: got %b required 0", bus.alu_ready);
    end
    clock_cycle();
    rst = 1'b0;
    drive_idle();
    #1;
    checks++;
    if (bus.alu_ready !== 1'b0 || bus.lsu_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_ready: alu_ready=%b lsu_ready=%b required 0/0", bus.alu_ready, bus.lsu_ready);
    end
    clock_cycle();
    checks++;
    if (bus.RegWrite !== 1'b0 || bus.busy_mask !== 32'd0 || bus.rd_addr !== 5'd0 || bus.write_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: RegWrite=%b busy=%h rd_addr=%0d data=%h required 0/0/0/0",
               bus.RegWrite, bus.busy_mask, bus.rd_addr, bus.write_data);
    end
  endtask

  task automatic test_single_alu();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
    clock_cycle();
    bus.issue_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b0 || bus.busy_mask[5] !== 1'b1) begin
      failures++;
      $display("FAIL alu_accept: alu_ready=%b lsu_ready=%b busy5=%b required 1/0/1",
               bus.alu_ready, bus.lsu_ready, bus.busy_mask[5]);
    end
    clock_cycle();
    bus.alu_valid = 1'b0;
    checks++;
    if (bus.RegWrite !== 1'b1 || bus.rd_addr !== 5'd5 || bus.write_data !== 32'hDEADBEEF || bus.busy_mask[5] !== 1'b1) begin
      failures++;
      $display("FAIL alu_commit: RegWrite=%b rd_addr=%0d data=%h busy5=%b required 1/5/deadbeef/1",
               bus.RegWrite, bus.rd_addr, bus.write_data, bus.busy_mask[5]);
    end
    clock_cycle();
    checks++;
    if (bus.RegWrite !== 1'b0 || bus.busy_mask[5] !== 1'b0 || bus.rd_addr !== 5'd5 || bus.write_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL alu_after: RegWrite=%b busy5=%b rd_addr=%0d data=%h required 0/0/5/deadbeef (held)",
               bus.RegWrite, bus.busy_mask[5], bus.rd_addr, bus.write_data);
    end
  endtask

  task automatic test_round_robin();
    bit          want_lsu [3] = '{1'b1, 1'b0, 1'b1};
    logic [4:0]  want_rd  [3] = '{5'd4, 5'd3, 5'd4};
    rst = 1'b1;
    clock_cycle();
    rst = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hA0A0A0A3;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'hB0B0B0B4;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (bus.lsu_ready !== want_lsu[k] || bus.alu_ready !== !want_lsu[k]) begin
        failures++;
        $display("FAIL rr_grant%0d: alu_ready=%b lsu_ready=%b required %b/%b",
                 k, bus.alu_ready, bus.lsu_ready, !want_lsu[k], want_lsu[k]);
      end
      clock_cycle();
      checks++;
      if (bus.RegWrite !== 1'b1 || bus.rd_addr !== want_rd[k]) begin
        failures++;
        $display("FAIL rr_commit%0d: RegWrite=%b rd_addr=%0d required 1/%0d", k, bus.RegWrite, bus.rd_addr, want_rd[k]);
      end
    end
    drive_idle();
    checks++;
    if (bus.write_data !== 32'hB0B0B0B4) begin
      failures++;
      $display("FAIL rr_data: write_data=%h required b0b0b0b4", bus.write_data);
    end
    clock_cycle();
  endtask

  task automatic test_x0();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h1234;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    #1;
    checks++;
    if (bus.lsu_ready !== 1'b1) begin
      failures++;
      $display("FAIL x0_ready: lsu_ready=%b required 1", bus.lsu_ready);
    end
    clock_cycle();
    drive_idle();
    checks++;
    if (bus.RegWrite !== 1'b0 || bus.busy_mask[0] !== 1'b0) begin
      failures++;
      $display("FAIL x0_commit: RegWrite=%b busy0=%b required 0/0", bus.RegWrite, bus.busy_mask[0]);
    end
    clock_cycle();
  endtask

  task automatic test_set_wins();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    clock_cycle();
    bus.issue_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77770001;
    clock_cycle();
    bus.alu_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    checks++;
    if (bus.RegWrite !== 1'b1 || bus.rd_addr !== 5'd7) begin
      failures++;
      $display("FAIL setwin_commit: RegWrite=%b rd_addr=%0d required 1/7", bus.RegWrite, bus.rd_addr);
    end
    clock_cycle();
    bus.issue_valid = 1'b0;
    checks++;
    if (bus.busy_mask[7] !== 1'b1) begin
      failures++;
      $display("FAIL setwin_busy: busy7=%b required 1", bus.busy_mask[7]);
    end
    clock_cycle();
    clock_cycle();
    checks++;
    if (bus.busy_mask[7] !== 1'b1) begin
      failures++;
      $display("FAIL setwin_hold: busy7=%b required 1", bus.busy_mask[7]);
    end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77770002;
    clock_cycle();
    bus.alu_valid = 1'b0;
    checks++;
    if (bus.busy_mask[7] !== 1'b1 || bus.RegWrite !== 1'b1) begin
      failures++;
      $display("FAIL setwin_second: busy7=%b RegWrite=%b required 1/1", bus.busy_mask[7], bus.RegWrite);
    end
    clock_cycle();
    checks++;
    if (bus.busy_mask[7] !== 1'b0) begin
      failures++;
      $display("FAIL setwin_clear: busy7=%b required 0", bus.busy_mask[7]);
    end
  endtask

  task automatic test_reset_mid();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    clock_cycle();
    bus.issue_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'hCAFEF00D;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_accept: alu_ready=%b required 1", bus.alu_ready);
    end
    clock_cycle();
    bus.alu_valid = 1'b0;
    rst = 1'b1;
    clock_cycle();
    rst = 1'b0;
    checks++;
    if (bus.RegWrite !== 1'b0 || bus.busy_mask !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_state: RegWrite=%b busy=%h required 0/0", bus.RegWrite, bus.busy_mask);
    end
    checks++;
    if (dut_rf[9] === 32'hCAFEF00D) begin
      failures++;
      $display("FAIL rstmid_lost: rf[9]=%h required not cafef00d", dut_rf[9]);
    end
    for (int r = 0; r < NREG; r++) begin
      checks++;
      if (dut_rf[r] !== m_rf[r]) begin
        failures++;
        $display("FAIL rstmid_rf%0d: got %h required %h", r, dut_rf[r], m_rf[r]);
      end
    end
  endtask

  task automatic test_random();
    bit alu_hold;
    bit lsu_hold;
    for (int c = 0; c < 400; c++) begin
      alu_hold = bus.alu_valid && !exp_alu_rdy;
      lsu_hold = bus.lsu_valid && !exp_lsu_rdy;
      if (!alu_hold) begin
        bus.alu_valid = 1'($urandom_range(0, 1));
        bus.alu_rd    = 5'($urandom_range(0, 31));
        bus.alu_data  = $urandom;
      end
      if (!lsu_hold) begin
        bus.lsu_valid = 1'($urandom_range(0, 1));
        bus.lsu_rd    = 5'($urandom_range(0, 31));
        bus.lsu_data  = $urandom;
      end
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_rd    = 5'($urandom_range(0, 31));
      predict_grants();
      #1;
      checks++;
      if (bus.alu_ready !== exp_alu_rdy || bus.lsu_ready !== exp_lsu_rdy) begin
        failures++;
        $display("FAIL rnd_ready c%0d: alu/lsu ready=%b/%b required %b/%b",
                 c, bus.alu_ready, bus.lsu_ready, exp_alu_rdy, exp_lsu_rdy);
      end
      clock_cycle();
      checks++;
      if (bus.RegWrite !== m_rw || bus.busy_mask !== m_busy ||
          (m_rw && (bus.rd_addr !== m_addr || bus.write_data !== m_data))) begin
        failures++;
        $display("FAIL rnd_out c%0d: RegWrite=%b rd=%0d data=%h busy=%h required %b/%0d/%h/%h",
                 c, bus.RegWrite, bus.rd_addr, bus.write_data, bus.busy_mask, m_rw, m_addr, m_data, m_busy);
      end
    end
    drive_idle();
    clock_cycle();
    clock_cycle();
    for (int r = 0; r < NREG; r++) begin
      checks++;
      if (dut_rf[r] !== m_rf[r]) begin
        failures++;
        $display("FAIL rnd_rf%0d: got %h required %h", r, dut_rf[r], m_rf[r]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_last_lsu = 1'b0; m_rw = 1'b0; m_addr = '0; m_data = '0; m_busy = '0;
    exp_alu_rdy = 1'b0; exp_lsu_rdy = 1'b0;
    rst = 1'b1;
    drive_idle();
    @(posedge clk);
    #1;
    test_reset();
    test_single_alu();
    test_round_robin();
    test_x0();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
